// File: rtl/cb_rd_sched_if.sv
// cb_rd_sched_if
//   Request-side bundle between the stage FSMs (master) and the CB port-A
//   read scheduler (slave). One lane per requester, fields packed by lane.
//   req_valid  : burst request, held until req_ready
//   req_ready  : one-hot accept pulse (slave -> master)
//   req_dest   : 3 bits/lane mapper destination
//   req_dir    : 2 bits/lane direction
//   req_base   : CB_AW bits/lane first row address
//   req_len    : SEQ_CNT_DW bits/lane row count
//   req_l_k_0  : landmark LSB per lane
//   req_done   : one-hot pulse when the last mapped row reaches the mapper
interface cb_rd_sched_if #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned CB_AW      = 10,
    parameter int unsigned SEQ_CNT_DW = 10
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*3-1:0]          req_dest;
    logic [NREQ*2-1:0]          req_dir;
    logic [NREQ*CB_AW-1:0]      req_base;
    logic [NREQ*SEQ_CNT_DW-1:0] req_len;
    logic [NREQ-1:0]            req_l_k_0;
    logic [NREQ-1:0]            req_done;

    modport master (
        output req_valid, req_dest, req_dir, req_base, req_len, req_l_k_0,
        input  req_ready, req_done
    );

    modport slave (
        input  req_valid, req_dest, req_dir, req_base, req_len, req_l_k_0,
        output req_ready, req_done
    );
endinterface

// File: rtl/cb_rd_sched.sv
// cb_rd_sched
//   Port-A read scheduler for the CB bank. Arbitrates four burst requesters,
//   issues one CB row read per cycle, and delays the mapper select fields by
//   the BRAM read latency so they line up with CB_douta.
// Ports
//   clk, sys_rst_n      : clock, asynchronous active-low reset
//   req_if (slave)      : requester bundle (valid/ready/fields/done)
//   CB_ena, CB_addra    : CB port-A read enable / address
//   CB_douta_sel        : {dest,dir} aligned to CB_douta, 0 when no valid row
//   l_k_0               : landmark LSB aligned to CB_douta
//   seq_cnt_dout_sel    : row index within burst, aligned to CB_douta
//   busy                : FSM not idle or select pipe holds a row
//   err_dest            : sticky, illegal dest accepted (reset clears)
// Configuration
//   CB_RD_SCHED_RR_EN   : defined -> round-robin arbitration,
//                         undefined -> fixed priority (req 0 highest)
module cb_rd_sched #(
    parameter int unsigned NREQ            = 4,
    parameter int unsigned CB_AW           = 10,
    parameter int unsigned SEQ_CNT_DW      = 10,
    parameter int unsigned CB_DOUTA_SEL_DW = 5,
    parameter int unsigned RD_LAT          = 1
) (
    input  logic                       clk,
    input  logic                       sys_rst_n,
    cb_rd_sched_if.slave               req_if,
    output logic                       CB_ena,
    output logic [CB_AW-1:0]           CB_addra,
    output logic [CB_DOUTA_SEL_DW-1:0] CB_douta_sel,
    output logic                       l_k_0,
    output logic [SEQ_CNT_DW-1:0]      seq_cnt_dout_sel,
    output logic                       busy,
    output logic                       err_dest
);
    localparam logic [2:0] DEST_TBA = 3'b100;
    localparam logic [1:0] DIR_NEW  = 2'b11;

    typedef enum logic [1:0] {IDLE, GRANT, BURST, DRAIN} state_t;

    typedef struct packed {
        logic                  vld;
        logic                  last;
        logic [1:0]            id;
        logic [2:0]            dest;
        logic [1:0]            dir;
        logic                  lk;
        logic [SEQ_CNT_DW-1:0] k;
    } pipe_t;

    state_t                state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [2:0]            dest_q, dest_d;
    logic [1:0]            dir_q, dir_d;
    logic                  lk_q, lk_d;
    logic [SEQ_CNT_DW-1:0] len_q, len_d;
    logic [SEQ_CNT_DW-1:0] k_q, k_d;
    logic [CB_AW-1:0]      addr_q, addr_d;
    logic                  err_q, err_d;
    logic [NREQ-1:0]       done_nr_q, done_nr_d;
    pipe_t                 pipe_q [RD_LAT];
    pipe_t                 pipe_in, pipe_out;
`ifdef CB_RD_SCHED_RR_EN
    logic [1:0]            rr_q, rr_d;
    logic [1:0]            rr_idx;
`endif

    logic                  win_any;
    logic [1:0]            win_idx;
    logic [NREQ-1:0]       ready_c;
    logic [NREQ-1:0]       done_pipe;
    logic                  pipe_any;
    logic [2:0]            in_dest;
    logic [1:0]            in_dir;
    logic [CB_AW-1:0]      in_base;
    logic [SEQ_CNT_DW-1:0] in_len;
    logic                  in_lk;
    logic [SEQ_CNT_DW-1:0] eff_len;
    logic                  illegal;

    // Arbitration
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
`ifdef CB_RD_SCHED_RR_EN
        rr_idx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rr_idx = rr_q + 2'(i);
            if (!win_any && req_if.req_valid[rr_idx]) begin
                win_any = 1'b1;
                win_idx = rr_idx;
            end
        end
`else
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_any && req_if.req_valid[i]) begin
                win_any = 1'b1;
                win_idx = 2'(i);
            end
        end
`endif
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        dest_d    = dest_q;
        dir_d     = dir_q;
        lk_d      = lk_q;
        len_d     = len_q;
        k_d       = k_q;
        addr_d    = addr_q;
        err_d     = err_q;
        done_nr_d = '0;
        ready_c   = '0;
        pipe_in   = '0;
`ifdef CB_RD_SCHED_RR_EN
        rr_d      = rr_q;
`endif
        in_dest = req_if.req_dest[gnt_q*3 +: 3];
        in_dir  = req_if.req_dir[gnt_q*2 +: 2];
        in_base = req_if.req_base[gnt_q*CB_AW +: CB_AW];
        in_len  = req_if.req_len[gnt_q*SEQ_CNT_DW +: SEQ_CNT_DW];
        in_lk   = req_if.req_l_k_0[gnt_q];
        eff_len = ((in_dest == DEST_TBA) && (in_dir == DIR_NEW)) ? SEQ_CNT_DW'(5) : in_len;
        illegal = (in_dest == 3'b000) || (in_dest[2:1] == 2'b11);

        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d = GRANT;
                    gnt_d   = win_idx;
                end
            end
            GRANT: begin
                // Winner withdrew before being accepted: drop it silently.
                if (req_if.req_valid[gnt_q]) begin
                    ready_c[gnt_q] = 1'b1;
                    dest_d = in_dest;
                    dir_d  = in_dir;
                    lk_d   = in_lk;
                    len_d  = eff_len;
                    addr_d = in_base;
                    k_d    = '0;
`ifdef CB_RD_SCHED_RR_EN
                    rr_d   = gnt_q + 2'd1;
`endif
                    if (illegal || (eff_len == '0)) begin
                        // No rows to map: completion is signalled directly.
                        done_nr_d[gnt_q] = 1'b1;
                        err_d   = err_q | illegal;
                        state_d = IDLE;
                    end else begin
                        state_d = BURST;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                pipe_in.vld  = 1'b1;
                pipe_in.last = (k_q == len_q - SEQ_CNT_DW'(1));
                pipe_in.id   = gnt_q;
                pipe_in.dest = dest_q;
                pipe_in.dir  = dir_q;
                pipe_in.lk   = lk_q;
                pipe_in.k    = k_q;
                addr_d = addr_q + CB_AW'(1);
                if (pipe_in.last) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + SEQ_CNT_DW'(1);
                end
            end
            DRAIN: begin
                // The final drain cycle carries req_done and doubles as the
                // arbitration slot so the next grant follows immediately.
                if (k_q == SEQ_CNT_DW'(RD_LAT - 1)) begin
                    k_d = '0;
                    if (win_any) begin
                        state_d = GRANT;
                        gnt_d   = win_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    k_d = k_q + SEQ_CNT_DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            dest_q    <= '0;
            dir_q     <= '0;
            lk_q      <= 1'b0;
            len_q     <= '0;
            k_q       <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            done_nr_q <= '0;
`ifdef CB_RD_SCHED_RR_EN
            rr_q      <= '0;
`endif
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            dest_q    <= dest_d;
            dir_q     <= dir_d;
            lk_q      <= lk_d;
            len_q     <= len_d;
            k_q       <= k_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            done_nr_q <= done_nr_d;
`ifdef CB_RD_SCHED_RR_EN
            rr_q      <= rr_d;
`endif
            pipe_q[0] <= pipe_in;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Outputs
    assign pipe_out = pipe_q[RD_LAT-1];

    always_comb begin
        pipe_any = 1'b0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            pipe_any = pipe_any | pipe_q[i].vld;
        end
    end

    always_comb begin
        CB_ena           = (state_q == BURST);
        CB_addra         = CB_ena ? addr_q : '0;
        CB_douta_sel     = '0;
        l_k_0            = 1'b0;
        seq_cnt_dout_sel = '0;
        done_pipe        = '0;
        if (pipe_out.vld) begin
            CB_douta_sel     = CB_DOUTA_SEL_DW'({pipe_out.dest, pipe_out.dir});
            l_k_0            = pipe_out.lk;
            seq_cnt_dout_sel = pipe_out.k;
            if (pipe_out.last) begin
                done_pipe[pipe_out.id] = 1'b1;
            end
        end
    end

    assign busy             = (state_q != IDLE) || pipe_any;
    assign err_dest         = err_q;
    assign req_if.req_ready = ready_c;
    assign req_if.req_done  = done_nr_q | done_pipe;
endmodule

// File: tb/tb_cb_rd_sched.sv
module tb_cb_rd_sched;
    localparam int unsigned NREQ       = 4;
    localparam int unsigned CB_AW      = 10;
    localparam int unsigned SEQ_CNT_DW = 10;
    localparam int unsigned SELW       = 5;
    localparam int unsigned RD_LAT     = 2;

    logic                  clk = 1'b0;
    logic                  sys_rst_n = 1'b0;
    logic                  CB_ena;
    logic [CB_AW-1:0]      CB_addra;
    logic [SELW-1:0]       CB_douta_sel;
    logic                  l_k_0;
    logic [SEQ_CNT_DW-1:0] seq_cnt_dout_sel;
    logic                  busy;
    logic                  err_dest;

    always #5 clk = ~clk;

    cb_rd_sched_if #(.NREQ(NREQ), .CB_AW(CB_AW), .SEQ_CNT_DW(SEQ_CNT_DW)) rif ();

    cb_rd_sched #(
        .NREQ(NREQ), .CB_AW(CB_AW), .SEQ_CNT_DW(SEQ_CNT_DW),
        .CB_DOUTA_SEL_DW(SELW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .sys_rst_n(sys_rst_n), .req_if(rif),
        .CB_ena(CB_ena), .CB_addra(CB_addra), .CB_douta_sel(CB_douta_sel),
        .l_k_0(l_k_0), .seq_cnt_dout_sel(seq_cnt_dout_sel),
        .busy(busy), .err_dest(err_dest)
    );

    typedef struct {
        int unsigned idx;
        int unsigned dest;
        int unsigned dir;
        int unsigned base;
        int unsigned len;
        int unsigned lk;
        int unsigned exp_reads;
        int unsigned exp_err;
    } vec_t;

    typedef struct {
        int unsigned cyc;
        int unsigned val;
        int unsigned lk;
        int unsigned k;
    } exp_t;

    exp_t        aq[$];
    exp_t        sq[$];
    exp_t        dq[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned last_done_cyc = 0;
    bit          sb_on   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: pops expected reads, aligned selects and completions
    always @(negedge clk) begin
        exp_t e;
        if (sb_on && sys_rst_n) begin
            if (CB_ena) begin
                if (aq.size() == 0) chk("unexpected_cb_ena", 1, 0);
                else begin
                    e = aq.pop_front();
                    chk("cb_addra", 32'(CB_addra), e.val);
                    chk("cb_ena_cycle", cyc, e.cyc);
                end
            end
            if (CB_douta_sel != '0) begin
                if (sq.size() == 0) chk("unexpected_sel", 32'(CB_douta_sel), 0);
                else begin
                    e = sq.pop_front();
                    chk("douta_sel", 32'(CB_douta_sel), e.val);
                    chk("l_k_0", 32'(l_k_0), e.lk);
                    chk("seq_cnt_dout_sel", 32'(seq_cnt_dout_sel), e.k);
                    chk("sel_cycle", cyc, e.cyc);
                end
            end
            if (rif.req_done != '0) begin
                if (dq.size() == 0) chk("unexpected_done", 32'(rif.req_done), 0);
                else begin
                    e = dq.pop_front();
                    chk("req_done", 32'(rif.req_done), e.val);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
        if (rif.req_done != '0) last_done_cyc = cyc;
    end

    task automatic wait_idle();
        int unsigned t;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (t == 200) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_drain();
        int unsigned t;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (aq.size() == 0 && sq.size() == 0 && dq.size() == 0 && !busy) break;
        end
        if (t == 300) chk("drain_timeout", 1, 0);
        chk("addr_left", aq.size(), 0);
        chk("sel_left", sq.size(), 0);
        chk("done_left", dq.size(), 0);
    endtask

    task automatic drive_fields(input int unsigned i, input int unsigned dest, input int unsigned dir,
                                input int unsigned base, input int unsigned len, input int unsigned lk);
        rif.req_dest[i*3 +: 3]                   = 3'(dest);
        rif.req_dir[i*2 +: 2]                    = 2'(dir);
        rif.req_base[i*CB_AW +: CB_AW]           = CB_AW'(base);
        rif.req_len[i*SEQ_CNT_DW +: SEQ_CNT_DW]  = SEQ_CNT_DW'(len);
        rif.req_l_k_0[i]                         = lk[0];
    endtask

    task automatic apply_vec(input vec_t v);
        int unsigned c;
        int unsigned t;
        exp_t e;
        wait_idle();
        @(posedge clk); #1;
        c = cyc;
        for (int unsigned k = 0; k < v.exp_reads; k++) begin
            e.cyc = c + 2 + k; e.val = (v.base + k) % 1024; e.lk = 0; e.k = 0;
            aq.push_back(e);
            e.cyc = c + 2 + RD_LAT + k; e.val = v.dest * 4 + v.dir; e.lk = v.lk; e.k = k;
            sq.push_back(e);
        end
        e.val = 32'(1) << v.idx; e.lk = 0; e.k = 0;
        e.cyc = (v.exp_reads == 0) ? c + 2 : c + 1 + v.exp_reads + RD_LAT;
        dq.push_back(e);
        drive_fields(v.idx, v.dest, v.dir, v.base, v.len, v.lk);
        rif.req_valid[v.idx] = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (rif.req_ready != '0) break;
        end
        if (t == 50) chk("ready_timeout", 1, 0);
        else begin
            chk("req_ready", 32'(rif.req_ready), 32'(1) << v.idx);
            chk("ready_cycle", cyc, c + 1);
            chk("busy_at_ready", 32'(busy), 1);
        end
        @(posedge clk); #1;
        rif.req_valid[v.idx] = 1'b0;
        wait_drain();
        chk("err_dest", 32'(err_dest), v.exp_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cb_ena"}, 32'(CB_ena), 0);
        chk({tag, "_cb_addra"}, 32'(CB_addra), 0);
        chk({tag, "_sel"}, 32'(CB_douta_sel), 0);
        chk({tag, "_l_k_0"}, 32'(l_k_0), 0);
        chk({tag, "_seq"}, 32'(seq_cnt_dout_sel), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err_dest), 0);
        chk({tag, "_ready"}, 32'(rif.req_ready), 0);
        chk({tag, "_done"}, 32'(rif.req_done), 0);
    endtask

    vec_t        vecs[9];
    int unsigned exp_order[4];
    int unsigned ng, gi, seen, t;
    bit          reraised;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          idx dest dir base  len lk reads err
        vecs[0] = '{0,  1,   1,  8,    4,  0, 4,    0};   // A/POS
        vecs[1] = '{2,  4,   3,  100,  9,  1, 5,    0};   // TBa/NEW forced to 5 rows
        vecs[2] = '{1,  2,   2,  1022, 4,  0, 4,    0};   // address wrap
        vecs[3] = '{3,  5,   3,  500,  2,  1, 2,    0};   // NL/NEW, not forced
        vecs[4] = '{1,  3,   0,  0,    0,  0, 0,    0};   // len 0
        vecs[5] = '{3,  7,   1,  5,    3,  0, 0,    1};   // illegal dest
        vecs[6] = '{0,  4,   1,  1023, 1,  1, 1,    1};   // TBa/POS single row
        vecs[7] = '{2,  0,   2,  7,    2,  0, 0,    1};   // illegal dest 000
        vecs[8] = '{1,  6,   0,  9,    5,  1, 0,    1};   // illegal dest 110
`ifdef CB_RD_SCHED_RR_EN
        exp_order = '{0, 1, 3, 0};
`else
        exp_order = '{0, 1, 0, 3};
`endif
        rif.req_valid = '0;
        rif.req_dest  = '0;
        rif.req_dir   = '0;
        rif.req_base  = '0;
        rif.req_len   = '0;
        rif.req_l_k_0 = '0;

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        sys_rst_n = 1'b1;
        sb_on = 1'b1;

        for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

        // Simultaneous requesters 0,1,3; requester 0 re-raised once 1 is accepted
        sb_on = 1'b0;
        wait_idle();
        for (int unsigned i = 0; i < NREQ; i++) drive_fields(i, 1, 1, 16 * i, 2, 0);
        @(posedge clk); #1;
        rif.req_valid = 4'b1011;
        ng = 0; reraised = 1'b0;
        for (t = 0; t < 400 && ng < 4; t++) begin
            @(negedge clk);
            if (rif.req_ready != '0) begin
                gi = 0;
                for (int unsigned j = 0; j < NREQ; j++) if (rif.req_ready[j]) gi = j;
                chk("arb_grant_order", gi, exp_order[ng]);
                if (ng > 0) chk("arb_back_to_back", cyc, last_done_cyc + 1);
                ng++;
                @(posedge clk); #1;
                rif.req_valid[gi] = 1'b0;
                if (gi == 1 && !reraised) begin
                    rif.req_valid[0] = 1'b1;
                    reraised = 1'b1;
                end
            end
        end
        if (ng < 4) chk("arb_timeout", ng, 4);
        rif.req_valid = '0;
        wait_idle();

        // Reset in the middle of a burst
        @(posedge clk); #1;
        drive_fields(0, 1, 1, 40, 20, 0);
        rif.req_valid[0] = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge clk);
            if (rif.req_ready[0]) break;
        end
        @(posedge clk); #1;
        rif.req_valid[0] = 1'b0;
        seen = 0;
        for (t = 0; t < 30 && seen < 3; t++) begin
            @(negedge clk);
            if (CB_ena) seen++;
        end
        chk("midrst_burst_started", seen, 3);
        @(posedge clk); #2;
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rif.req_done != '0 || CB_ena) seen++;
        end
        sys_rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rif.req_done != '0 || CB_ena || busy) seen++;
        end
        chk("midrst_quiet_after", seen, 0);
        aq.delete(); sq.delete(); dq.delete();
        sb_on = 1'b1;
        apply_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
